// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_ctrl
//  Description : DES round sequencer. Accepts a block, drives load, 16 Feistel
//                rounds with the C/D rotate schedule, final capture and a
//                valid/ready result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module des_round_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       decrypt,
    input  logic       abort,
    output logic       ld_data,
    output logic       rnd_en,
    output logic [3:0] round,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       fin_cap,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd15;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_mode;
    logic       w_mode_nxt;
    logic [1:0] w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Rounds 1, 2, 9 and 16 rotate by one; decrypt skips the first rotate so
    // that its right-rotates walk the encrypt subkeys in reverse order.
    always_comb begin
        w_shift = 2'd2;
        if (r_cnt == 4'd0) begin
            w_shift = r_mode ? 2'd0 : 2'd1;
        end else if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == c_LAST_ROUND) begin
            w_shift = 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        start_ready = 1'b0;
        ld_data     = 1'b0;
        rnd_en      = 1'b0;
        fin_cap     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        round       = 4'd0;
        key_shift   = 2'd0;

        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                start_ready = ~abort;
                w_cnt_nxt   = 4'd0;
                if (start_valid && !abort) begin
                    w_state_nxt = S_LOAD;
                    w_mode_nxt  = decrypt;
                end
            end
            S_LOAD: begin
                ld_data     = 1'b1;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                rnd_en    = 1'b1;
                round     = r_cnt;
                key_shift = w_shift;
                if (r_cnt == c_LAST_ROUND) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_FINAL;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_FINAL: begin
                fin_cap     = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Cancel wins over every transition outside IDLE, dropping any result.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end
    end

    assign key_dir = r_mode;

endmodule
`default_nettype wire
